lbp_engine: RTL and testbench

- Parametrised successor of the fixed 128x128 local-binary-pattern engine.
- Reads grayscale pixels from the host image memory, which has a 1-cycle read latency, and computes an 8-bit LBP code per pixel against a configurable threshold. Writes results back through a valid/ready output handshake.
- Keeps a 3x3 window register so each step along a row reads only the 3 new-column pixels, not 9.
- Optional border mode emits code 0 for frame-edge pixels, so the output covers the full frame.

---
 rtl/lbp_pkg.sv | 9 +
 rtl/lbp_window_cmp.sv | 36 +++
 rtl/lbp_engine.sv | 127 ++++++++++++
 tb/tb_lbp_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared state encoding and window geometry for the LBP engine
package lbp_pkg;
    typedef enum logic [2:0] {IDLE, FILL, SHIFT, CALC, BORDER, OUT, DONE} state_e;
    localparam logic [3:0] CENTER = 4'd4;
    // window slot of each neighbour, indexed by its bit weight in the code
    localparam logic [3:0] NBR_IDX [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
    localparam logic [1:0] FILL_DX [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    localparam logic [1:0] FILL_DY [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
endpackage

// File: rtl/lbp_window_cmp.sv
// lbp_window_cmp: 3x3 pixel window with column shift, slot load and LBP code generation
module lbp_window_cmp
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_i,
    input  logic          load_i,
    input  logic [3:0]    load_idx_i,
    input  logic [DW-1:0] load_data_i,
    input  logic [DW-1:0] thresh_i,
    output logic [7:0]    code_o
);
    logic [8:0][DW-1:0] win_q, win_d;
    logic [DW:0]        limit;
    always_comb begin
        win_d = win_q;
        if (shift_i)
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
        if (load_i)
            win_d[load_idx_i] = load_data_i;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) win_q <= '0;
        else       win_q <= win_d;
    // one extra bit keeps center+thresh from wrapping
    assign limit = {1'b0, win_q[CENTER]} + {1'b0, thresh_i};
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign code_o[i] = {1'b0, win_q[NBR_IDX[i]]} >= limit;
    end
endmodule

// File: rtl/lbp_engine.sv
// lbp_engine: raster-scan LBP engine with pipelined image reads and a valid/ready result port
module lbp_engine
    import lbp_pkg::*;
#(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int DW       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DW-1:0]                cfg_thresh,
    input  logic                         cfg_border,
    output logic [ROW_BITS+COL_BITS-1:0] gray_addr,
    output logic                         gray_req,
    input  logic [DW-1:0]                gray_data,
    output logic [ROW_BITS+COL_BITS-1:0] lbp_addr,
    output logic [7:0]                   lbp_data,
    output logic                         lbp_valid,
    input  logic                         lbp_ready,
    output logic                         finish
);
    state_e              state_q, state_d;
    logic [COL_BITS-1:0] x_q, x_d, nx, x_min, x_max, ax;
    logic [ROW_BITS-1:0] y_q, y_d, ny, y_min, y_max, ay;
    logic [3:0]          cnt_q, cnt_d, rd_idx, rd_idx_q;
    logic [DW-1:0]       thresh_q, thresh_d;
    logic                border_q, border_d, rd_vld_q, row_end, last, nxt_edge;
    logic [7:0]          lbp_q, lbp_d, code;

    lbp_window_cmp #(.DW(DW)) u_win (
        .clk        (clk),
        .reset      (reset),
        .shift_i    (state_q == SHIFT && cnt_q == 4'd0),
        .load_i     (rd_vld_q),
        .load_idx_i (rd_idx_q),
        .load_data_i(gray_data),
        .thresh_i   (thresh_q),
        .code_o     (code)
    );

    assign x_min    = border_q ? '0 : COL_BITS'(1);
    assign y_min    = border_q ? '0 : ROW_BITS'(1);
    assign x_max    = border_q ? '1 : ~COL_BITS'(1);
    assign y_max    = border_q ? '1 : ~ROW_BITS'(1);
    assign row_end  = x_q == x_max;
    assign last     = row_end && y_q == y_max;
    assign nx       = row_end ? x_min : x_q + 1'b1;
    assign ny       = row_end ? y_q + 1'b1 : y_q;
    assign nxt_edge = border_q && (nx == '0 || nx == '1 || ny == '0 || ny == '1);

    // FILL walks the window in raster order; SHIFT fetches only the new right column
    assign gray_req  = (state_q == FILL && cnt_q < 4'd9) || (state_q == SHIFT && cnt_q < 4'd3);
    assign rd_idx    = state_q == FILL ? cnt_q : 4'(3 * cnt_q + 2);
    assign ax        = state_q == FILL ? x_q + COL_BITS'(FILL_DX[cnt_q]) - 1'b1 : x_q + 1'b1;
    assign ay        = y_q + ROW_BITS'(state_q == FILL ? FILL_DY[cnt_q] : cnt_q[1:0]) - 1'b1;
    assign gray_addr = gray_req ? {ay, ax} : '0;
    assign lbp_valid = state_q == OUT;
    assign lbp_addr  = lbp_valid ? {y_q, x_q} : '0;
    assign lbp_data  = lbp_q;
    assign finish    = state_q == DONE;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        lbp_d    = lbp_q;
        thresh_d = thresh_q;
        border_d = border_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                thresh_d = cfg_thresh;
                border_d = cfg_border;
                x_d      = cfg_border ? '0 : COL_BITS'(1);
                y_d      = cfg_border ? '0 : ROW_BITS'(1);
                cnt_d    = '0;
                state_d  = cfg_border ? BORDER : FILL;
            end
            FILL: begin
                cnt_d   = cnt_q == 4'd9 ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == 4'd9 ? CALC : FILL;
            end
            SHIFT: begin
                cnt_d   = cnt_q == 4'd3 ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == 4'd3 ? CALC : SHIFT;
            end
            CALC: begin
                lbp_d   = code;
                state_d = OUT;
            end
            BORDER: begin
                lbp_d   = '0;
                state_d = OUT;
            end
            OUT: if (lbp_ready) begin
                x_d     = nx;
                y_d     = ny;
                state_d = last ? DONE : nxt_edge ? BORDER : nx == COL_BITS'(1) ? FILL : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= COL_BITS'(1);
            y_q      <= ROW_BITS'(1);
            cnt_q    <= '0;
            lbp_q    <= '0;
            thresh_q <= '0;
            border_q <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            lbp_q    <= lbp_d;
            thresh_q <= thresh_d;
            border_q <= border_d;
            rd_vld_q <= gray_req;
            rd_idx_q <= rd_idx;
        end
endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine: scoreboard bench for lbp_engine on an 8x8 image
module tb_lbp_engine;
    localparam int CB = 3, RB = 3, W = 8, H = 8, DW = 8;
    localparam int TOT_RD = (H - 2) * (9 + 3 * (W - 3));

    typedef struct {
        logic [5:0] addr;
        logic [7:0] code;
        int         rd;
        int         gap;
    } exp_t;

    logic       clk = 0, reset = 1, start = 0, cfg_border = 0, lbp_ready = 1;
    logic [7:0] cfg_thresh = 0, gray_data, lbp_data;
    logic [5:0] gray_addr, lbp_addr;
    logic       gray_req, lbp_valid, finish;
    logic [7:0] mem [64];
    exp_t       sb[$];
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0, rd_cnt = 0, rd_tot = 0, prev_acc = -1, stall_left = 0, wr_idx = 0;
    logic [5:0] last_acc = '0;
    bit         fin_chk = 0, stalled = 0;

    lbp_engine #(.COL_BITS(CB), .ROW_BITS(RB), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_thresh(cfg_thresh),
        .cfg_border(cfg_border),
        .gray_addr (gray_addr),
        .gray_req  (gray_req),
        .gray_data (gray_data),
        .lbp_addr  (lbp_addr),
        .lbp_data  (lbp_data),
        .lbp_valid (lbp_valid),
        .lbp_ready (lbp_ready),
        .finish    (finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (gray_req) gray_data <= mem[gray_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input int x, input int y, input logic [7:0] th);
        int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        logic [8:0] lim;
        logic [7:0] c;
        lim = 9'(mem[6'(y * W + x)]) + 9'(th);
        for (int i = 0; i < 8; i++)
            c[i] = {1'b0, mem[6'((y + dy[i]) * W + x + dx[i])]} >= lim;
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] th, input logic bd);
        int lo = bd ? 0 : 1;
        exp_t e;
        for (int y = lo; y < H - lo; y++)
            for (int x = lo; x < W - lo; x++) begin
                bit is_edge = x == 0 || y == 0 || x == W - 1 || y == H - 1;
                e.addr = 6'(y * W + x);
                e.code = is_edge ? 8'h00 : model(x, y, th);
                e.rd   = is_edge ? 0 : (x == 1 ? 9 : 3);
                e.gap  = is_edge ? 2 : (x == 1 ? 12 : 6);
                sb.push_back(e);
            end
    endtask

    task automatic start_frame(input logic [7:0] th, input logic bd, input int stall);
        push_frame(th, bd);
        @(negedge clk);
        cfg_thresh = th;
        cfg_border = bd;
        rd_cnt     = 0;
        rd_tot     = 0;
        prev_acc   = -1;
        wr_idx     = 0;
        stall_left = stall;
        start      = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_frame(input logic [7:0] th, input logic bd, input int stall);
        int i;
        start_frame(th, bd, stall);
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (finish && sb.size() == 0) break;
        end
        check("frame_done", i < 5000, 1);
        check("reads_total", rd_tot, TOT_RD);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (fin_chk) begin
                check("finish_rise", finish, 1);
                fin_chk = 0;
            end
            if (gray_req) begin
                rd_cnt++;
                rd_tot++;
            end
            lbp_ready = 1;
            if (lbp_valid && wr_idx == 2 && stall_left > 0 && sb.size() > 0) begin
                lbp_ready = 0;
                stall_left--;
                stalled = 1;
                check("stall_addr", lbp_addr, sb[0].addr);
                check("stall_data", lbp_data, sb[0].code);
                check("stall_req", gray_req, 0);
            end
            if (lbp_valid && lbp_ready) begin
                if (sb.size() == 0) check("extra_write_valid", lbp_valid, 0);
                else begin
                    e = sb.pop_front();
                    check("addr", lbp_addr, e.addr);
                    check("code", lbp_data, e.code);
                    check("reads", rd_cnt, e.rd);
                    check("finish_low", finish, 0);
                    if (prev_acc >= 0 && !stalled) check("gap", cyc - prev_acc, e.gap);
                    prev_acc = cyc;
                    stalled  = 0;
                    rd_cnt   = 0;
                    last_acc = lbp_addr;
                    wr_idx++;
                    if (sb.size() == 0) fin_chk = 1;
                end
            end
        end
    end

    initial begin
        int i;
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        repeat (3) @(negedge clk);
        check("rst_gray_req", gray_req, 0);
        check("rst_gray_addr", gray_addr, 0);
        check("rst_valid", lbp_valid, 0);
        check("rst_lbp_addr", lbp_addr, 0);
        check("rst_lbp_data", lbp_data, 0);
        check("rst_finish", finish, 0);
        reset = 0;
        run_frame(8'd0, 1'b0, 0);
        run_frame(8'd0, 1'b1, 0);
        run_frame(8'd0, 1'b0, 5);
        for (int k = 0; k < 64; k++) mem[k] = 8'd50;
        run_frame(8'd0, 1'b0, 0);
        run_frame(8'd1, 1'b0, 0);
        for (int k = 0; k < 64; k++) mem[k] = 8'd255;
        mem[3 * W + 3] = 8'd250;
        run_frame(8'd10, 1'b0, 0);
        for (int k = 0; k < 64; k++) mem[k] = 8'($urandom_range(0, 255));
        run_frame(8'($urandom_range(0, 20)), 1'b1, 0);
        run_frame(8'd0, 1'b0, 0);
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        start_frame(8'd0, 1'b0, 0);
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (last_acc == 6'(3 * W + 2)) break;
        end
        check("reach_row3", i < 2000, 1);
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gray_req) break;
        end
        check("reach_shift", i < 20, 1);
        #2 reset = 1;
        #1;
        check("arst_gray_req", gray_req, 0);
        check("arst_gray_addr", gray_addr, 0);
        check("arst_valid", lbp_valid, 0);
        check("arst_lbp_addr", lbp_addr, 0);
        check("arst_lbp_data", lbp_data, 0);
        check("arst_finish", finish, 0);
        sb.delete();
        fin_chk = 0;
        @(negedge clk);
        reset = 0;
        run_frame(8'd0, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
